// File: rtl/raw_stream_gen.sv
// Synthetic raster source: emits 12-bit Bayer-domain test patterns with
// horizontal/vertical blanking on the same X/Y/DATA/DVAL stream as the capture stage.
module raw_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK_CYC = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oFRAME_DONE,
    output logic [15:0] oFrame_Cont,
    output logic        oBUSY
);

    typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;

    localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK_CYC - 1);

    state_t      state, state_n;
    logic [15:0] blank_cnt, blank_cnt_n;
    logic [1:0]  mode_q, mode_n;
    logic        stop_pending, stop_n;
    logic [10:0] x_n, y_n;
    logic [11:0] data_n;
    logic        dval_n, done_n, load_px;
    logic [15:0] frames_n;

    function automatic logic [11:0] pattern(input logic [1:0] mode,
                                            input logic [10:0] px,
                                            input logic [10:0] py);
        logic [11:0] v;
        case (mode)
            2'd0: begin
                case ({py[0], px[0]})
                    2'b00:   v = 12'h800;
                    2'b01:   v = 12'hFFF;
                    2'b10:   v = 12'h000;
                    default: v = 12'h800;
                endcase
            end
            2'd1:    v = {px, 1'b0};
            2'd2:    v = {py, 1'b0};
            default: v = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
        endcase
        return v;
    endfunction

    // The output X/Y registers double as the raster position counters;
    // they simply hold through blanking and after a stop.
    always_comb begin
        state_n     = state;
        blank_cnt_n = blank_cnt;
        mode_n      = mode_q;
        stop_n      = stop_pending | iSTOP;
        x_n         = oX_Cont;
        y_n         = oY_Cont;
        load_px     = 1'b0;
        done_n      = 1'b0;
        frames_n    = oFrame_Cont;
        case (state)
            IDLE: begin
                stop_n = 1'b0;
                if (iSTART && !iSTOP) begin
                    state_n = LINE;
                    mode_n  = iMODE;
                    x_n     = '0;
                    y_n     = '0;
                    load_px = 1'b1;
                end
            end
            LINE: begin
                blank_cnt_n = '0;
                if (oX_Cont != X_LAST) begin
                    x_n     = oX_Cont + 11'd1;
                    load_px = 1'b1;
                end else if (oY_Cont != Y_LAST) begin
                    state_n = HBLANK;
                end else begin
                    state_n  = VBLANK;
                    done_n   = 1'b1;
                    frames_n = oFrame_Cont + 16'd1;
                end
            end
            HBLANK: begin
                blank_cnt_n = blank_cnt + 16'd1;
                if (blank_cnt == HB_LAST) begin
                    state_n = LINE;
                    x_n     = '0;
                    y_n     = oY_Cont + 11'd1;
                    load_px = 1'b1;
                end
            end
            VBLANK: begin
                blank_cnt_n = blank_cnt + 16'd1;
                // A stop seen on the very last blanking cycle still ends the run here.
                if (blank_cnt == VB_LAST) begin
                    if (stop_pending || iSTOP) begin
                        state_n = IDLE;
                        stop_n  = 1'b0;
                    end else begin
                        state_n = LINE;
                        mode_n  = iMODE;
                        x_n     = '0;
                        y_n     = '0;
                        load_px = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        dval_n = load_px;
        data_n = load_px ? pattern(mode_n, x_n, y_n) : oDATA;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            blank_cnt    <= '0;
            mode_q       <= '0;
            stop_pending <= 1'b0;
            oX_Cont      <= '0;
            oY_Cont      <= '0;
            oDATA        <= '0;
            oDVAL        <= 1'b0;
            oFRAME_DONE  <= 1'b0;
            oFrame_Cont  <= '0;
            oBUSY        <= 1'b0;
        end else begin
            state        <= state_n;
            blank_cnt    <= blank_cnt_n;
            mode_q       <= mode_n;
            stop_pending <= stop_n;
            oX_Cont      <= x_n;
            oY_Cont      <= y_n;
            oDATA        <= data_n;
            oDVAL        <= dval_n;
            oFRAME_DONE  <= done_n;
            oFrame_Cont  <= frames_n;
            oBUSY        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_raw_stream_gen.sv
// Bench for raw_stream_gen: directed scenarios plus random traffic, all checked
// against a frame-position model built from the raster timing arithmetic.
module tb_raw_stream_gen;

    localparam int H       = 8;
    localparam int V       = 4;
    localparam int HB      = 2;
    localparam int VB      = 3;
    localparam int LINELEN = H + HB;
    localparam int SPAN    = V * LINELEN - HB;
    localparam int PERIOD  = SPAN + VB;

    logic        iCLK = 1'b0;
    logic        iRST, iSTART, iSTOP;
    logic [1:0]  iMODE;
    logic [10:0] oX_Cont, oY_Cont;
    logic [11:0] oDATA;
    logic        oDVAL, oFRAME_DONE, oBUSY;
    logic [15:0] oFrame_Cont;

    int n_checks = 0;
    int n_errors = 0;
    int n_dval   = 0;
    int n_done   = 0;

    always #5 iCLK = ~iCLK;

    raw_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK_CYC(VB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iMODE(iMODE),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oDATA(oDATA), .oDVAL(oDVAL),
        .oFRAME_DONE(oFRAME_DONE), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
    );

    function automatic logic [11:0] ref_pixel(input logic [1:0] mode, input int x, input int y);
        case (mode)
            2'd0: begin
                if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
                else            return (x % 2 == 0) ? 12'h000 : 12'h800;
            end
            2'd1:    return 12'(x * 2);
            2'd2:    return 12'(y * 2);
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    // Model state: whether a frame is running and the cycle position inside it.
    bit          m_run = 0;
    int          m_p   = 0;
    logic [1:0]  m_mode = 0;
    bit          m_stop = 0;
    logic [10:0] m_x = 0, m_y = 0;
    logic [11:0] m_data = 0;
    bit          m_dval = 0, m_done = 0, m_busy = 0;
    logic [15:0] m_frames = 0;

    always @(posedge iCLK) begin
        if (iRST) begin
            m_run = 0; m_p = 0; m_mode = 0; m_stop = 0;
            m_x = 0; m_y = 0; m_data = 0;
            m_dval = 0; m_done = 0; m_busy = 0; m_frames = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                m_stop = 0;
                m_dval = 0;
                if (iSTART && !iSTOP) begin
                    m_run = 1; m_p = 0; m_mode = iMODE;
                end
            end else begin
                if (iSTOP) m_stop = 1;
                m_p = m_p + 1;
                if (m_p == PERIOD) begin
                    if (m_stop) begin
                        m_run = 0; m_dval = 0; m_stop = 0;
                    end else begin
                        m_p = 0; m_mode = iMODE;
                    end
                end
            end
            if (m_run) begin
                if (m_p < SPAN && (m_p % LINELEN) < H) begin
                    m_dval = 1;
                    m_x    = 11'(m_p % LINELEN);
                    m_y    = 11'(m_p / LINELEN);
                    m_data = ref_pixel(m_mode, m_p % LINELEN, m_p / LINELEN);
                end else begin
                    m_dval = 0;
                    if (m_p == SPAN) begin
                        m_done   = 1;
                        m_frames = m_frames + 16'd1;
                    end
                end
            end
            m_busy = m_run;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    // One clock: wait for the falling edge, compare every output, tally events.
    task automatic applyStimulus();
        @(negedge iCLK);
        checkOutput("dval",   32'(oDVAL),       32'(m_dval));
        checkOutput("done",   32'(oFRAME_DONE), 32'(m_done));
        checkOutput("busy",   32'(oBUSY),       32'(m_busy));
        checkOutput("frames", 32'(oFrame_Cont), 32'(m_frames));
        checkOutput("x",      32'(oX_Cont),     32'(m_x));
        checkOutput("y",      32'(oY_Cont),     32'(m_y));
        checkOutput("data",   32'(oDATA),       32'(m_data));
        if (oDVAL) n_dval++;
        if (oFRAME_DONE) n_done++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic waitPixel(input int x, input int y);
        int budget;
        budget = 4 * PERIOD;
        while (!(m_dval && m_x == 11'(x) && m_y == 11'(y)) && budget > 0) begin
            applyStimulus();
            budget--;
        end
        checkOutput("wait_pixel_timeout", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        iRST = 1; iSTART = 0; iSTOP = 0; iMODE = 2'd1;
        runCycles(2);
        checkOutput("reset_x", 32'(oX_Cont), 32'd0);
        iRST = 0;
        runCycles(2);

        // Three back-to-back ramp frames with start held.
        n_dval = 0; n_done = 0;
        iSTART = 1;
        runCycles(3 * PERIOD);
        checkOutput("ramp_valid_pixels", 32'(n_dval), 32'd96);
        checkOutput("ramp_frame_dones",  32'(n_done), 32'd3);
        checkOutput("ramp_frame_count",  32'(oFrame_Cont), 32'd3);

        // Bayer flat pattern over two frames.
        iMODE = 2'd0;
        runCycles(2 * PERIOD);

        // Mode switched mid-frame only affects the following frame.
        iMODE = 2'd1;
        runCycles(PERIOD + 10);
        iMODE = 2'd3;
        runCycles(PERIOD + 31);

        // Stop requested mid-frame: the frame completes, then the block goes idle.
        n_dval = 0; n_done = 0;
        waitPixel(0, 0);
        n_dval = 1;
        waitPixel(3, 1);
        iSTOP = 1; iSTART = 0;
        applyStimulus();
        iSTOP = 0;
        runCycles(PERIOD);
        checkOutput("stop_valid_pixels", 32'(n_dval), 32'd32);
        checkOutput("stop_frame_dones",  32'(n_done), 32'd1);
        checkOutput("stop_busy_low",     32'(oBUSY),  32'd0);

        // Reset in the middle of a line, then restart.
        iSTART = 1; iMODE = 2'd2;
        waitPixel(5, 2);
        iRST = 1;
        applyStimulus();
        checkOutput("rst_dval", 32'(oDVAL), 32'd0);
        iRST = 0; iSTART = 0;
        applyStimulus();
        iSTART = 1;
        applyStimulus();
        checkOutput("restart_dval", 32'(oDVAL), 32'd1);

        // Start and stop together while idle must not start a frame.
        iRST = 1; iSTART = 0;
        applyStimulus();
        iRST = 0; iSTART = 1; iSTOP = 1;
        runCycles(10);
        checkOutput("start_stop_busy", 32'(oBUSY), 32'd0);
        iSTOP = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            iSTART = ($urandom % 4) != 0;
            iSTOP  = ($urandom % 60) == 0;
            iMODE  = 2'($urandom);
            iRST   = ($urandom % 700) == 0;
            applyStimulus();
        end
        iRST = 0; iSTOP = 0;
        runCycles(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
